// File: rtl/life_gen_scheduler.sv
// Game of Life generation sequencer: config load handshake, raster sweep, buffer swap.
// Ports: clk/rst; i_load/i_step/i_run commands; i_load_busy, o_load_go loader link;
// o_sweep_valid/x/y raster stream; o_buf_sel, o_gen_done, o_gen_count, o_busy status.
module life_gen_scheduler #(
  parameter int FIELD_W = 64,
  parameter int FIELD_H = 48,
  parameter int TICKS_PER_GEN = 1000,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_run,
  input  logic                  i_load_busy,
  output logic                  o_load_go,
  output logic                  o_sweep_valid,
  output logic [X_ADR_SIZE-1:0] o_sweep_x,
  output logic [Y_ADR_SIZE-1:0] o_sweep_y,
  output logic                  o_buf_sel,
  output logic                  o_gen_done,
  output logic [15:0]           o_gen_count,
  output logic                  o_busy
);

  localparam int TW = (TICKS_PER_GEN > 1) ? $clog2(TICKS_PER_GEN) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_GEN - 1);
  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_START,
    LOAD_WAIT,
    SWEEP,
    SWAP
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          load_pending;
  logic          seen_busy;

  // Strobes decode straight from the state register.
  assign o_load_go     = (state == LOAD_START);
  assign o_sweep_valid = (state == SWEEP);
  assign o_gen_done    = (state == SWAP);
  assign o_busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      load_pending <= 1'b0;
      seen_busy    <= 1'b0;
      o_sweep_x    <= '0;
      o_sweep_y    <= '0;
      o_buf_sel    <= 1'b0;
      o_gen_count  <= '0;
    end else begin
      // Loads arriving while busy are held until the next IDLE.
      if (state != IDLE && i_load)
        load_pending <= 1'b1;

      unique case (state)
        IDLE: begin
          if (load_pending || i_load) begin
            state        <= LOAD_START;
            load_pending <= 1'b0;
            tick_cnt     <= '0;
          end else if (i_step || (i_run && tick_cnt == TICK_LAST)) begin
            state     <= SWEEP;
            tick_cnt  <= '0;
            o_sweep_x <= '0;
            o_sweep_y <= '0;
          end else if (i_run) begin
            tick_cnt <= tick_cnt + 1'b1;
          end else begin
            tick_cnt <= '0;
          end
        end

        LOAD_START: begin
          seen_busy <= 1'b0;
          state     <= LOAD_WAIT;
        end

        // Wait for a full busy pulse so a slow-starting loader is not missed.
        LOAD_WAIT: begin
          if (i_load_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            state       <= IDLE;
            o_gen_count <= '0;
          end
        end

        SWEEP: begin
          if (o_sweep_x == X_LAST) begin
            o_sweep_x <= '0;
            if (o_sweep_y == Y_LAST) begin
              o_sweep_y <= '0;
              state     <= SWAP;
            end else begin
              o_sweep_y <= o_sweep_y + 1'b1;
            end
          end else begin
            o_sweep_x <= o_sweep_x + 1'b1;
          end
        end

        SWAP: begin
          o_buf_sel   <= ~o_buf_sel;
          o_gen_count <= o_gen_count + 16'd1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed self-checking bench for life_gen_scheduler (4x3 field, 5-tick period).
// Ports: none; drives the DUT and prints a single summary line.
module tb_life_gen_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_load = 1'b0;
  logic        i_step = 1'b0;
  logic        i_run = 1'b0;
  logic        i_load_busy = 1'b0;
  logic        o_load_go;
  logic        o_sweep_valid;
  logic [1:0]  o_sweep_x;
  logic [1:0]  o_sweep_y;
  logic        o_buf_sel;
  logic        o_gen_done;
  logic [15:0] o_gen_count;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  life_gen_scheduler #(
    .FIELD_W(4),
    .FIELD_H(3),
    .TICKS_PER_GEN(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_load(i_load),
    .i_step(i_step),
    .i_run(i_run),
    .i_load_busy(i_load_busy),
    .o_load_go(o_load_go),
    .o_sweep_valid(o_sweep_valid),
    .o_sweep_x(o_sweep_x),
    .o_sweep_y(o_sweep_y),
    .o_buf_sel(o_buf_sel),
    .o_gen_done(o_gen_done),
    .o_gen_count(o_gen_count),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;

    // Reset, with a step request riding on it
    i_step = 1'b1;
    ticks(2);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_valid", int'(o_sweep_valid), 0);
    chk("rst_go", int'(o_load_go), 0);
    chk("rst_done", int'(o_gen_done), 0);
    chk("rst_buf", int'(o_buf_sel), 0);
    chk("rst_cnt", int'(o_gen_count), 0);
    chk("rst_x", int'(o_sweep_x), 0);
    chk("rst_y", int'(o_sweep_y), 0);
    rst = 1'b0;
    i_step = 1'b0;
    tick();
    chk("rst_nosweep", int'(o_sweep_valid), 0);
    chk("rst_idle", int'(o_busy), 0);

    // Single step
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("step_valid", int'(o_sweep_valid), 1);
      chk("step_x", int'(o_sweep_x), i % 4);
      chk("step_y", int'(o_sweep_y), i / 4);
      tick();
    end
    chk("step_done", int'(o_gen_done), 1);
    chk("step_swapvalid", int'(o_sweep_valid), 0);
    chk("step_swapbuf", int'(o_buf_sel), 0);
    tick();
    chk("step_done_low", int'(o_gen_done), 0);
    chk("step_buf", int'(o_buf_sel), 1);
    chk("step_cnt", int'(o_gen_count), 1);
    chk("step_idle", int'(o_busy), 0);

    // Load handshake (buf_sel=1 must survive)
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    chk("load_go", int'(o_load_go), 1);
    tick();
    chk("load_go_low", int'(o_load_go), 0);
    chk("load_wait_busy", int'(o_busy), 1);
    i_step = 1'b1;
    i_load_busy = 1'b1;
    tick();
    i_step = 1'b0;
    chk("load_step_ignored", int'(o_sweep_valid), 0);
    ticks(11);
    chk("load_still_busy", int'(o_busy), 1);
    i_load_busy = 1'b0;
    tick();
    chk("load_end_idle", int'(o_busy), 0);
    chk("load_cnt", int'(o_gen_count), 0);
    chk("load_buf", int'(o_buf_sel), 1);

    // Run mode from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    i_run = 1'b1;
    ticks(4);
    chk("run_pre", int'(o_sweep_valid), 0);
    tick();
    chk("run_first", int'(o_sweep_valid), 1);
    for (int g = 2; g <= 3; g++) begin
      ticks(17);
      chk("run_gap", int'(o_sweep_valid), 0);
      tick();
      chk("run_period", int'(o_sweep_valid), 1);
      chk("run_x0", int'(o_sweep_x), 0);
      chk("run_y0", int'(o_sweep_y), 0);
    end
    ticks(13);
    chk("run_cnt3", int'(o_gen_count), 3);
    chk("run_buf3", int'(o_buf_sel), 1);
    ticks(5);
    chk("run_fourth", int'(o_sweep_valid), 1);
    ticks(5);
    i_run = 1'b0;
    ticks(8);
    chk("run_stop_idle", int'(o_busy), 0);
    chk("run_cnt4", int'(o_gen_count), 4);
    chk("run_buf4", int'(o_buf_sel), 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_sweep_valid) cnt++;
    end
    chk("run_no_more", cnt, 0);

    // Load latched during a sweep; step alongside it in IDLE is dropped
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    ticks(5);
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    chk("latch_sweep_on", int'(o_sweep_valid), 1);
    ticks(6);
    chk("latch_swap", int'(o_gen_done), 1);
    tick();
    chk("latch_idle", int'(o_busy), 0);
    chk("latch_idle_go", int'(o_load_go), 0);
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    chk("latch_go", int'(o_load_go), 1);
    chk("latch_step_drop", int'(o_sweep_valid), 0);
    tick();
    chk("latch_wait", int'(o_sweep_valid), 0);
    i_load_busy = 1'b1;
    ticks(3);
    i_load_busy = 1'b0;
    tick();
    chk("latch_end", int'(o_busy), 0);
    chk("latch_cnt", int'(o_gen_count), 0);
    chk("latch_buf", int'(o_buf_sel), 1);
    tick();
    chk("latch_no_step", int'(o_sweep_valid), 0);

    // Counter wrap
    force dut.o_gen_count = 16'hFFFF;
    tick();
    release dut.o_gen_count;
    tick();
    chk("wrap_pre", int'(o_gen_count), 65535);
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (o_gen_done) cnt++;
    end
    chk("wrap_done_once", cnt, 1);
    chk("wrap_cnt", int'(o_gen_count), 0);
    chk("wrap_buf", int'(o_buf_sel), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
